// File: rtl/jtag_prog_pkg.sv
// Shared types and frame layout for the program-RAM serial loader transmitter.
package jtag_prog_pkg;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = ADDR_W + 1 + DATA_W;
  localparam int BIT_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READY = 3'd2,
    ST_SHIFT = 3'd3,
    ST_UPD   = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // Bit 0 of the frame is shifted first, so data LSB leads and addr MSB trails.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                     input logic par,
                                                     input logic [DATA_W-1:0] data);
    return {addr, par, data};
  endfunction
endpackage

// File: rtl/jtag_prog_if.sv
// Write-request bus and serial strobe outputs of the loader transmitter.
interface jtag_prog_if;
  import jtag_prog_pkg::*;
  logic              sess_req;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_par;
  logic [DATA_W-1:0] wr_data;
  logic              sel;
  logic              drck;
  logic              tdi;
  logic              update;
  logic              busy;
  logic [15:0]       frame_cnt;

  modport master (output sess_req, wr_valid, wr_addr, wr_par, wr_data,
                  input  wr_ready, sel, drck, tdi, update, busy, frame_cnt);
  modport slave  (input  sess_req, wr_valid, wr_addr, wr_par, wr_data,
                  output wr_ready, sel, drck, tdi, update, busy, frame_cnt);
endinterface

// File: rtl/jtag_prog_clkdiv.sv
// Half-period counter: phase_tick pulses on the last of every CLK_DIV cycles.
module jtag_prog_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic phase_tick
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)         cnt <= '0;
    else if (cnt == CNT_MAX)  cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign phase_tick = (cnt == CNT_MAX);
endmodule

// File: rtl/jtag_prog_tx.sv
// Serial program-RAM loader transmitter: frames {addr,par,data} onto sel/drck/tdi/update.
// Optional JTAG_PROG_AUTOINC_EN replaces wr_addr with an internal auto-incrementing address.
module jtag_prog_tx
  import jtag_prog_pkg::*;
#(
  parameter int CLK_DIV = 4  // clk cycles per drck half-period, >= 2
) (
  input  logic       clk,
  input  logic       reset,
  jtag_prog_if.slave bus
);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  state_e             state, state_nx;
  logic               phase_tick, div_clr, phase_hi;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] frame_q;
  logic [15:0]        frame_cnt_q;
  logic [ADDR_W-1:0]  addr_sel;
  logic               accept, gap_entry, sess_open;
  logic               rdy, sel, drck, tdi, upd;

  jtag_prog_clkdiv #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .reset      (reset),
    .clr        (div_clr),
    .phase_tick (phase_tick)
  );

  assign accept    = (state == ST_READY) && bus.sess_req && bus.wr_valid;
  assign gap_entry = (state == ST_UPD) && phase_tick;
  assign sess_open = (state == ST_IDLE) && bus.sess_req;

`ifdef JTAG_PROG_AUTOINC_EN
  logic [ADDR_W-1:0] addr_q;
  always_ff @(posedge clk) begin
    if (reset)          addr_q <= '0;
    else if (sess_open) addr_q <= '0;
    else if (gap_entry) addr_q <= addr_q + ADDR_W'(1);
  end
  assign addr_sel = addr_q;
`else
  assign addr_sel = bus.wr_addr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase_hi    <= 1'b0;
      bit_cnt     <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (sess_open)      frame_cnt_q <= '0;
      else if (gap_entry) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (accept) begin
        frame_q  <= build_frame(addr_sel, bus.wr_par, bus.wr_data);
        bit_cnt  <= '0;
        phase_hi <= 1'b0;
      end else if (state == ST_SHIFT && phase_tick) begin
        phase_hi <= ~phase_hi;
        // bit_cnt parks on the last bit so tdi keeps F[19] through UPD/GAP
        if (phase_hi && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Divider is held clear in IDLE/READY so SETUP and SHIFT start on a fresh phase.
  always_comb begin
    state_nx = state;
    div_clr  = 1'b0;
    rdy      = 1'b0;
    sel      = 1'b0;
    drck     = 1'b0;
    tdi      = 1'b0;
    upd      = 1'b0;
    case (state)
      ST_IDLE: begin
        div_clr = 1'b1;
        if (bus.sess_req) state_nx = ST_SETUP;
      end
      ST_SETUP: begin
        sel = 1'b1;
        if (phase_tick) state_nx = ST_READY;
      end
      ST_READY: begin
        sel     = 1'b1;
        div_clr = 1'b1;
        rdy     = bus.sess_req;
        if (!bus.sess_req)    state_nx = ST_IDLE;
        else if (bus.wr_valid) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        sel  = 1'b1;
        drck = phase_hi;
        tdi  = frame_q[bit_cnt];
        if (phase_tick && phase_hi && bit_cnt == LAST_BIT) state_nx = ST_UPD;
      end
      ST_UPD: begin
        sel = 1'b1;
        upd = 1'b1;
        tdi = frame_q[bit_cnt];
        if (phase_tick) state_nx = ST_GAP;
      end
      ST_GAP: begin
        sel = 1'b1;
        tdi = frame_q[bit_cnt];
        if (phase_tick) state_nx = ST_READY;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.wr_ready  = rdy;
  assign bus.sel       = sel;
  assign bus.drck      = drck;
  assign bus.tdi       = tdi;
  assign bus.update    = upd;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_jtag_prog_tx.sv
// Directed + randomized bench for jtag_prog_tx; a shift-chain/RAM model watches the serial pins.
module tb_jtag_prog_tx;
  localparam int D  = 4;
  localparam int FW = 20;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   sess_idx = 0;

  jtag_prog_if bus ();

  jtag_prog_tx #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observation model: 20-bit chain clocked by drck rises, RAM written on update rise.
  logic [FW-1:0] chain = '0;
  logic [7:0]    ram [int];
  logic          drck_p = 1'b0, upd_p = 1'b0;
  int            upd_w = 0;
  int            rise_q[$], upd_q[$], updw_q[$], fc_q[$], acc_q[$];
  logic [FW-1:0] got_q[$], exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.drck && !drck_p) begin
      chain = {bus.tdi, chain[FW-1:1]};
      rise_q.push_back(cyc);
    end
    if (bus.update && !upd_p) begin
      got_q.push_back(chain);
      upd_q.push_back(cyc);
      ram[int'(chain[19:9])] = chain[7:0];
      upd_w = 0;
    end
    if (bus.update) upd_w++;
    if (!bus.update && upd_p) begin
      updw_q.push_back(upd_w);
      fc_q.push_back(int'(bus.frame_cnt));
    end
    drck_p = bus.drck;
    upd_p  = bus.update;
  endtask

  task automatic clear_q();
    rise_q.delete(); upd_q.delete(); updw_q.delete(); fc_q.delete();
    acc_q.delete(); got_q.delete(); exp_q.delete();
  endtask

  task automatic do_frame(input logic [10:0] a, input logic p, input logic [7:0] d, input bit hold);
    int n = 0;
    #1;
    while (!bus.wr_ready && n < 1000) begin step(); n++; end
    chk("rdy_wait", bus.wr_ready, 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_par   = p;
    bus.wr_data  = d;
    acc_q.push_back(cyc);
`ifdef JTAG_PROG_AUTOINC_EN
    exp_q.push_back({11'(sess_idx), p, d});
`else
    exp_q.push_back({a, p, d});
`endif
    sess_idx++;
    step();
    if (!hold) bus.wr_valid = 1'b0;
    bus.wr_addr = 11'($urandom);
    bus.wr_par  = 1'($urandom);
    bus.wr_data = 8'($urandom);
  endtask

  task automatic wait_upd(input int n);
    int k = 0;
    while (updw_q.size() < n && k < 3000) begin step(); k++; end
    chk("wait_upd", updw_q.size(), n);
  endtask

  initial begin
    int base, t0, n;
    bit saw_rdy;
    logic [10:0] ra;
    logic [7:0]  rd;
    logic        rp;

    reset = 1'b1;
    bus.sess_req = 1'b0; bus.wr_valid = 1'b0;
    bus.wr_addr = '0; bus.wr_par = 1'b0; bus.wr_data = '0;
    repeat (3) step();
    chk("rst_outs", {bus.sel, bus.drck, bus.tdi, bus.update, bus.busy, bus.wr_ready}, 0);
    chk("rst_fcnt", bus.frame_cnt, 0);
    reset = 1'b0;
    step();

    // session open: sel next cycle, wr_ready CLK_DIV cycles after that
    bus.sess_req = 1'b1;
    step();
    chk("open_sel", bus.sel, 1);
    chk("open_busy", bus.busy, 1);
    chk("open_nrdy", bus.wr_ready, 0);
    repeat (D - 1) step();
    chk("setup_nrdy", bus.wr_ready, 0);
    step();
    chk("setup_rdy", bus.wr_ready, 1);
    chk("open_fcnt", bus.frame_cnt, 0);

    // close with a simultaneous wr_valid that must not be taken
    bus.sess_req = 1'b0; bus.wr_valid = 1'b1;
    #1 chk("close_rdy", bus.wr_ready, 0);
    step();
    chk("close_sel", bus.sel, 0);
    chk("close_busy", bus.busy, 0);
    n = rise_q.size();
    repeat (12) step();
    chk("close_noshift", rise_q.size(), n);
    chk("close_idle", bus.busy, 0);
    bus.wr_valid = 1'b0;

    // single directed frame with full drck timing
    clear_q(); sess_idx = 0;
    bus.sess_req = 1'b1;
    do_frame(11'h2A5, 1'b1, 8'hC3, 1'b0);
    wait_upd(1);
    chk("f0_nrise", rise_q.size(), FW);
    for (int k = 0; k < FW && k < rise_q.size(); k++)
      chk($sformatf("f0_rise%0d", k), rise_q[k], acc_q[0] + 1 + (2*k+1)*D);
    chk("f0_frame", got_q[0], exp_q[0]);
    chk("f0_upd_cyc", upd_q[0], acc_q[0] + 1 + 40*D);
    chk("f0_upd_w", updw_q[0], D);
    chk("f0_fcnt", fc_q[0], 1);

    // back-to-back frames with wr_valid held
    do_frame(11'h000, 1'($urandom), 8'h11, 1'b1);
    do_frame(11'h001, 1'($urandom), 8'h22, 1'b1);
    do_frame(11'h7FF, 1'($urandom), 8'h33, 1'b0);
    wait_upd(4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("b2b_frame%0d", i), got_q[i], exp_q[i]);
      chk($sformatf("b2b_ram%0d", i), ram[int'(exp_q[i][19:9])], exp_q[i][7:0]);
      chk($sformatf("b2b_gap%0d", i), upd_q[i] - upd_q[i-1], 42*D + 1);
    end

    // randomized frames, last one always releases wr_valid
    for (int i = 0; i < 4; i++) begin
      ra = 11'($urandom); rp = 1'($urandom); rd = 8'($urandom);
      do_frame(ra, rp, rd, (i < 3) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    wait_upd(8);
    for (int i = 4; i < 8; i++) begin
      chk($sformatf("rnd_frame%0d", i), got_q[i], exp_q[i]);
      chk($sformatf("rnd_updcyc%0d", i), upd_q[i], acc_q[i] + 1 + 40*D);
      chk($sformatf("rnd_updw%0d", i), updw_q[i], D);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("fcnt%0d", i), fc_q[i], i + 1);
    chk("fcnt_now", bus.frame_cnt, 8);

    // sess_req dropped mid-SHIFT: frame completes, then session closes
    do_frame(11'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    t0 = acc_q[8];
    repeat (50) step();
    bus.sess_req = 1'b0;
    saw_rdy = 1'b0; n = 0;
    while (bus.sel && n < 1000) begin
      step(); n++;
      if (bus.wr_ready) saw_rdy = 1'b1;
    end
    chk("drop_nupd", upd_q.size(), 9);
    chk("drop_frame", got_q[got_q.size()-1], exp_q[8]);
    chk("drop_sel_cyc", cyc, t0 + 2 + 42*D);
    chk("drop_noready", saw_rdy, 0);
    chk("drop_fcnt", bus.frame_cnt, 9);
    chk("drop_busy", bus.busy, 0);

    // reset during bit 10 of a frame
    sess_idx = 0;
    bus.sess_req = 1'b1;
    base = rise_q.size();
    do_frame(11'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    t0 = acc_q[9];
    while (cyc < t0 + 1 + 20*D + 1) step();
    chk("rst_mid_bits", rise_q.size() - base, 10);
    chk("rst_mid_sel", bus.sel, 1);
    reset = 1'b1; bus.sess_req = 1'b0;
    step();
    chk("rst_mid_outs", {bus.sel, bus.drck, bus.tdi, bus.update, bus.busy, bus.wr_ready}, 0);
    chk("rst_mid_fcnt", bus.frame_cnt, 0);
    reset = 1'b0;
    n = upd_q.size();
    repeat (200) step();
    chk("rst_mid_noupd", upd_q.size(), n);
    chk("rst_mid_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtag_prog_tx.md
Name: jtag_prog_tx

Overview:
- Fabric-side transmitter for the PicoBlaze program-RAM serial loader interface.
- Takes byte-wide write requests and generates the serial strobes the loader consumes on its write port: sel, drck, tdi and update.
- Lets an on-chip source (SPI-flash boot engine, MIDI SysEx patch loader) rewrite the controller program with no JTAG cable attached.
- Sits between that source and the BSCAN-replacement inputs of the program ROM wrapper.

Parameters:
- CLK_DIV, 4: clk cycles per drck half-period; minimum 2.
- ADDR_W, 11: byte address width of the write port.
- DATA_W, 8: data byte width.
- FRAME_W, 20: bits per frame = ADDR_W + 1 (parity) + DATA_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sess_req  in  1  hold high to keep a load session open
- wr_valid  in  1  write request present
- wr_ready  out  1  request accepted this cycle when wr_valid is also high
- wr_addr  in  ADDR_W  byte address
- wr_par  in  1  parity bit (instruction bit 16/17 slice)
- wr_data  in  DATA_W  data byte
- sel  out  1  session select; target holds its processor in reset while high
- drck  out  1  shift clock, idles low
- tdi  out  1  serial data
- update  out  1  write strobe; target writes on the rising edge
- busy  out  1  high in every state except IDLE
- frame_cnt  out  16  frames completed this session; wraps modulo 2^16

Behaviour:
- Reset (synchronous): all outputs 0, FSM to IDLE, frame_cnt=0. Takes effect at the next clk edge, including mid-frame.
- Reset mid-frame abandons the frame with no update pulse. The partial shift is harmless.
- Frame word: F = {addr, par, data}. Shifted LSB first: F[0]=data[0] first, F[19]=addr[10] last.
- FSM states: IDLE, SETUP, READY, SHIFT, UPD, GAP.
- IDLE:
  - sel=0, wr_ready=0.
  - sess_req=1 -> SETUP; clear frame_cnt.
- SETUP: sel=1; hold CLK_DIV cycles -> READY.
- READY:
  - sel=1; wr_ready=1 only while sess_req=1.
  - wr_valid&wr_ready: latch F -> SHIFT.
  - sess_req=0 -> IDLE, sel drops the next cycle. A wr_valid in that same cycle is not accepted.
- SHIFT, with the accept cycle numbered 0 and D=CLK_DIV:
  - Bit k low phase starts at cycle 1+2kD: drck=0, tdi=F[k].
  - Bit k high phase starts at cycle 1+(2k+1)D: drck=1, tdi held.
  - tdi is stable from D cycles before each drck rise through D cycles after it.
  - Ends after bit 19's high phase -> UPD.
- UPD:
  - update=1, drck=0, for D cycles starting at cycle 1+40D.
  - tdi holds F[19].
- GAP:
  - update=0 for D cycles.
  - frame_cnt increments on GAP entry.
  - Then -> READY.
- Throughput: one word per 42D+1 cycles with wr_valid held high.
- sess_req falling during SHIFT/UPD/GAP: the frame completes, then READY sees sess_req=0 and goes to IDLE.
- wr_* are sampled only on the accept cycle; later changes are ignored.
- Counters: the divide counter is ceil(log2(CLK_DIV)) bits; the bit counter is 5 bits and terminates at 19.

Optional Feature:
- Macro: JTAG_PROG_AUTOINC_EN.
- Defined:
  - An internal ADDR_W-bit address register replaces wr_addr.
  - It is cleared on SETUP entry and incremented on GAP entry.
  - It wraps at 2^ADDR_W-1 -> 0.
  - wr_addr is ignored.
- Undefined: wr_addr is used directly; no address register exists.

Decomposition:
- Shared package jtag_prog_pkg holds:
  - state enum and state encodings;
  - FRAME_W derivation;
  - the frame bit-order function building F from addr/par/data.
- One sub-module: jtag_prog_clkdiv, the half-period counter emitting a phase_tick pulse every CLK_DIV cycles. The FSM owns all other logic.

Test Plan:
- Session open/close, CLK_DIV=4: sess_req 0->1 -> sel=1 next cycle, wr_ready=1 exactly 4 cycles later; sess_req 1->0 -> sel=0 and busy=0 next cycle.
- Single frame, addr=0x2A5, par=1, data=0xC3: sample tdi on 20 drck rises -> bits {data LSB-first, par, addr LSB-first}; update rises at cycle 161 and stays high 4 cycles; frame_cnt=1.
- Shift-chain model on the outputs (20-bit chain clocked by drck, write on update rise): back-to-back frames to 0x000, 0x001, 0x7FF with data 0x11/0x22/0x33 -> model RAM matches; frames 169 cycles apart.
- sess_req dropped mid-SHIFT: the frame finishes with an update pulse, then sel=0; no further wr_ready.
- reset asserted at bit 10 of a frame: all outputs 0 next cycle, no update pulse, frame_cnt=0.
- JTAG_PROG_AUTOINC_EN defined: 3 frames with wr_addr=0x555 -> shifted addresses 0x000, 0x001, 0x002; a preset at 0x7FF wraps to 0x000.
